// File: rtl/intr_ctrl.sv
// intr_ctrl: interrupt controller between NUM_SRC peripheral request lines
// and a CPU's single intr/inta handshake.
//
// Sources are latched as rising-edge or level requests, chosen per bit by
// EDGE_MODE, and filtered by a writable mask. Fixed priority applies, with
// index 0 highest. The controller hands the CPU an ISR vector address.
// Only one interrupt is serviced at a time, and it ends with an eoi pulse.
//
// Handshake: intr is held high while the controller is in REQ. The CPU
// acknowledges with a rising edge on inta. The winner is taken from the
// unmasked pending bits seen at that edge, and vector/irq_id are valid from
// the next cycle until eoi. The CPU must drop inta before the ISR counts as
// in service. An eoi pulse then releases the controller back to IDLE.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   irq_src    raw request lines, synchronous to clk
//   mask_we    mask write strobe
//   mask_wdata new mask value (1 = masked)
//   mask       current mask register
//   intr       interrupt request to the CPU
//   inta       interrupt acknowledge from the CPU
//   vector     ISR address of the source being serviced
//   irq_id     id being serviced; NUM_SRC marks a spurious acknowledge
//   in_service high while an ISR is active
//   eoi        one-cycle end-of-interrupt pulse
//   pending    raw pending bits, before masking
//   state_dbg  current FSM state (0 IDLE, 1 REQ, 2 ACK, 3 SERVICE)
module intr_ctrl #(
    parameter int                  NUM_SRC    = 8,
    parameter int                  ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]   VEC_BASE   = ADDR_W'(32'h0000_0100),
    parameter int                  VEC_STRIDE = 4,
    parameter logic [NUM_SRC-1:0]  EDGE_MODE  = {NUM_SRC{1'b1}},
    parameter logic [NUM_SRC-1:0]  MASK_RST   = {NUM_SRC{1'b0}},
    localparam int                 ID_W       = $clog2(NUM_SRC + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    output logic [NUM_SRC-1:0] mask,
    output logic               intr,
    input  logic               inta,
    output logic [ADDR_W-1:0]  vector,
    output logic [ID_W-1:0]    irq_id,
    output logic               in_service,
    input  logic               eoi,
    output logic [NUM_SRC-1:0] pending,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_ACK     = 2'd2,
        S_SERVICE = 2'd3
    } state_t;

    state_t             state;
    logic [NUM_SRC-1:0] irq_q;     // previous sample of irq_src (edge history)
    logic               inta_q;    // previous sample of inta
    logic               spurious;  // current acknowledge had no winner
    logic [NUM_SRC-1:0] req;
    logic               inta_rise;
    logic               win_found;
    logic [ID_W-1:0]    win_idx;
    logic [ID_W-1:0]    sel_id;
    logic [ADDR_W-1:0]  sel_vec;
    logic [NUM_SRC-1:0] ack_clr;

    assign req       = pending & ~mask;
    assign inta_rise = inta & ~inta_q;
    assign state_dbg = state;

    // Lowest-index set bit of req. The loop runs downward, so the last hit
    // is the lowest index and no early exit is needed.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(i);
            end
        end
    end

    // A spurious acknowledge reports id NUM_SRC and the vector slot just past
    // the last real source. The vector sum wraps in ADDR_W bits.
    assign sel_id  = win_found ? win_idx : ID_W'(NUM_SRC);
    assign sel_vec = VEC_BASE + ADDR_W'(sel_id) * ADDR_W'(VEC_STRIDE);

    // The winner is cleared only if it is an edge source. A level source
    // simply follows its input.
    always_comb begin
        ack_clr = '0;
        if (state == S_REQ && inta_rise && win_found) begin
            ack_clr = (NUM_SRC'(1) << win_idx) & EDGE_MODE;
        end
    end

    // Edge bits are sticky, and a new edge beats a same-cycle clear. Level
    // bits are the registered input. Bits latch regardless of the mask.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q   <= '0;
            inta_q  <= 1'b0;
            pending <= '0;
            mask    <= MASK_RST;
        end else begin
            irq_q   <= irq_src;
            inta_q  <= inta;
            pending <= (EDGE_MODE & ((pending & ~ack_clr) | (irq_src & ~irq_q)))
                     | (~EDGE_MODE & irq_src);
            if (mask_we) begin
                mask <= mask_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            intr       <= 1'b0;
            vector     <= '0;
            irq_id     <= '0;
            in_service <= 1'b0;
            spurious   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        intr  <= 1'b1;
                        state <= S_REQ;
                    end
                end
                S_REQ: begin
                    // The acknowledge edge takes precedence over a request
                    // that vanished in the same cycle. That case is the
                    // spurious acknowledge.
                    if (inta_rise) begin
                        irq_id   <= sel_id;
                        vector   <= sel_vec;
                        spurious <= ~win_found;
                        intr     <= 1'b0;
                        state    <= S_ACK;
                    end else if (!(|req)) begin
                        intr  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_ACK: begin
                    if (!inta) begin
                        if (spurious) begin
                            vector   <= '0;
                            irq_id   <= '0;
                            spurious <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            in_service <= 1'b1;
                            state      <= S_SERVICE;
                        end
                    end
                end
                S_SERVICE: begin
                    if (eoi) begin
                        in_service <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
